// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: shares the six 7-segment digits among NUM_REQ requesters.
// Round-robin grant, minimum dwell before preemption, one blank cycle between owners.
module hex_display_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*48-1:0] req_hex,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic [7:0]            hex0,
  output logic [7:0]            hex1,
  output logic [7:0]            hex2,
  output logic [7:0]            hex3,
  output logic [7:0]            hex4,
  output logic [7:0]            hex5
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("hex_display_arbiter: NUM_REQ must be 2..4");
    end
  endgenerate

  localparam int             CW        = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0]  DWELL_MAX = CW'(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t                       state, state_d;
  logic [NUM_REQ-1:0][47:0]     req_hex_a;
  logic [NUM_REQ-1:0]           own_oh, gnt_d;
  logic [1:0]                   pick, owner_d, rr_last, rr_last_d;
  logic                         pick_vld, exit_own;
  logic [47:0]                  pick_hex, own_hex, hex_q, hex_d;
  logic [CW-1:0]                dwell, dwell_d;

  assign req_hex_a = req_hex;
  assign busy      = (state == OWN);
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_q;

  // Round-robin pick: lowest rotation distance k from rr_last wins, so the
  // previous owner (k = NUM_REQ) is always the last choice.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (((int'(rr_last) + k) % NUM_REQ) == i)) begin
          pick     = 2'(i);
          pick_vld = 1'b1;
        end
      end
    end
  end

  // Select patterns for current owner and candidate; loop mux avoids an
  // out-of-range index when NUM_REQ is not a power of two.
  always_comb begin
    own_hex  = '1;
    pick_hex = '1;
    own_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 2'(i)) begin
        own_hex   = req_hex_a[i];
        own_oh[i] = 1'b1;
      end
      if (pick == 2'(i)) pick_hex = req_hex_a[i];
    end
  end

  // Release always wins; preemption only once dwell is satisfied and someone else waits.
  assign exit_own = ~|(req & own_oh) || ((dwell == DWELL_MAX) && |(req & ~own_oh));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; GAP lasts exactly one cycle and then decides like IDLE
  always_comb begin
    state_d = state;
    case (state)
      OWN:     state_d = exit_own ? GAP : OWN;
      default: state_d = pick_vld ? OWN : IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping
  always_comb begin
    gnt_d     = gnt;
    owner_d   = owner;
    rr_last_d = rr_last;
    dwell_d   = dwell;
    hex_d     = '1;
    case (state)
      OWN: begin
        if (exit_own) begin
          gnt_d = '0;
        end else begin
          hex_d   = own_hex;
          dwell_d = (dwell == DWELL_MAX) ? dwell : dwell + CW'(1);
        end
      end
      default: begin
        if (pick_vld) begin
          gnt_d     = NUM_REQ'(1) << pick;
          owner_d   = pick;
          rr_last_d = pick;
          dwell_d   = '0;
          hex_d     = pick_hex;
        end else begin
          gnt_d = '0;
        end
      end
    endcase
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      owner   <= '0;
      rr_last <= 2'(NUM_REQ - 1);
      dwell   <= '0;
      hex_q   <= '1;
    end else begin
      gnt     <= gnt_d;
      owner   <= owner_d;
      rr_last <= rr_last_d;
      dwell   <= dwell_d;
      hex_q   <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter (NUM_REQ=3, DWELL_CYCLES=4) with an
// ownership-level reference model.
module tb_hex_display_arbiter;
  localparam int N = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*48-1:0] req_hex;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic [7:0]   hex0, hex1, hex2, hex3, hex4, hex5;

  int checks = 0;
  int errors = 0;

  // Model: who owns the display (-1 none), how long, who had it last.
  int          m_own  = -1;
  int          m_held = 0;
  int          m_last = N - 1;
  logic [1:0]  m_owner = 2'd0;
  logic [47:0] m_hex  = '1;

  hex_display_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .req(req), .req_hex(req_hex), .gnt(gnt), .owner(owner),
    .busy(busy), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [53:0] obs();
    return {gnt, busy, owner, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  function automatic logic [53:0] expv();
    logic [2:0] g;
    g = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
    return {g, (m_own >= 0), m_owner, m_hex};
  endfunction

  // Advance the model with the inputs present before the edge, then clock.
  task automatic tick();
    if (rst) begin
      m_own = -1; m_held = 0; m_last = N - 1; m_owner = 2'd0; m_hex = '1;
    end else if (m_own >= 0) begin
      logic [N-1:0] others;
      others = req & ~N'(1 << m_own);
      if (!req[m_own] || (m_held >= D && others != 0)) begin
        m_own = -1; m_hex = '1;
      end else begin
        m_held++;
        m_hex = req_hex[48*m_own +: 48];
      end
    end else begin
      int p;
      p = -1;
      for (int k = 1; k <= N; k++)
        if (p < 0 && req[(m_last + k) % N]) p = (m_last + k) % N;
      if (p >= 0) begin
        m_own = p; m_last = p; m_held = 0; m_owner = 2'(p);
        m_hex = req_hex[48*p +: 48];
      end else m_hex = '1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; req_hex = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL reset_model cyc%0d got %h want %h", c, obs(), expv());
      end
      checks++;
      if ({gnt, busy, hex5, hex4, hex3, hex2, hex1, hex0} !== {3'b000, 1'b0, {48{1'b1}}}) begin
        errors++; $display("FAIL reset_blank cyc%0d got gnt=%b busy=%b hex0=%h", c, gnt, busy, hex0);
      end
    end
    rst = 1'b0; req = '0;
    tick();
  endtask

  task automatic test_single();
    req = 3'b010;
    req_hex[95:48] = 48'hC0F9A4B09992;
    tick();
    checks++;
    if ({gnt, hex0, hex5} !== {3'b010, 8'h92, 8'hC0}) begin
      errors++; $display("FAIL single_grant got gnt=%b hex0=%h hex5=%h want 010 92 C0", gnt, hex0, hex5);
    end
    for (int c = 0; c < 20; c++) begin
      if (c >= 10) req_hex = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (gnt !== 3'b010 || obs() !== expv()) begin
        errors++; $display("FAIL single_hold cyc%0d got %h want %h", c, obs(), expv());
      end
    end
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single_release cyc%0d got %h want %h", c, obs(), expv());
      end
    end
  endtask

  task automatic test_preempt();
    logic [2:0] want [0:6];
    want = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100};
    req = 3'b001;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) req = 3'b101;
      checks++;
      if (gnt !== want[c] || obs() !== expv()) begin
        errors++; $display("FAIL preempt cyc%0d got gnt=%b %h want gnt=%b %h", c, gnt, obs(), want[c], expv());
      end
      if (c == 5) begin
        checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {48{1'b1}}) begin
          errors++; $display("FAIL preempt_gap_blank got %h want all FF", {hex5, hex4, hex3, hex2, hex1, hex0});
        end
      end
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_rr();
    int seq [$];
    logic [2:0] prev;
    prev = gnt;
    req = 3'b111;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL rr_model cyc%0d got %h want %h", c, obs(), expv());
      end
      if (prev == 3'b000 && gnt != 3'b000) seq.push_back(int'(owner));
      prev = gnt;
    end
    checks++;
    if (seq.size() != 7) begin
      errors++; $display("FAIL rr_count got %0d grants want 7", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] != i % 3) begin
        errors++; $display("FAIL rr_order grant%0d got %0d want %0d", i, seq[i], i % 3);
      end
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_release();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b010;
    tick();
    req = 3'b001;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL release_model cyc%0d got %h want %h", c, obs(), expv());
      end
    end
    checks++;
    if (gnt !== 3'b001) begin
      errors++; $display("FAIL release_regrant got %b want 001", gnt);
    end
  endtask

  task automatic test_midreset();
    req = 3'b011; rst = 1'b1;
    tick();
    checks++;
    if ({gnt, busy, hex0, hex5} !== {3'b000, 1'b0, 8'hFF, 8'hFF} || obs() !== expv()) begin
      errors++; $display("FAIL midreset got gnt=%b busy=%b hex0=%h want 000 0 FF", gnt, busy, hex0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 3'b001 || obs() !== expv()) begin
      errors++; $display("FAIL midreset_regrant got gnt=%b %h want 001 %h", gnt, obs(), expv());
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      req_hex = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cyc%0d got %h want %h", c, obs(), expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_hex = '1;
    test_reset();
    test_single();
    test_preempt();
    test_rr();
    test_release();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
